// File: rtl/tx_ofdm_pkg.sv
// Shared constants, buffer states and subcarrier/bin mapping helpers for the OFDM transmitter.
package tx_ofdm_pkg;

  localparam int N_CBPS = 48;
  localparam int N_SC   = 64;

  localparam logic [5:0] PILOT_BIN_P7  = 6'd7;
  localparam logic [5:0] PILOT_BIN_P21 = 6'd21;
  localparam logic [5:0] PILOT_BIN_M21 = 6'd43;
  localparam logic [5:0] PILOT_BIN_M7  = 6'd57;
  localparam logic [5:0] DC_BIN        = 6'd0;
  localparam logic [5:0] NULL_LO       = 6'd27;
  localparam logic [5:0] NULL_HI       = 6'd37;
  localparam logic [5:0] LAST_BIN      = 6'(N_SC - 1);

  localparam logic [1:0] VAL_POS  = 2'b01;
  localparam logic [1:0] VAL_NEG  = 2'b11;
  localparam logic [1:0] VAL_ZERO = 2'b00;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2,
    BUF_OUTPUT  = 2'd3
  } buf_state_e;

  // Data slot (ascending subcarrier order) to IFFT bin.
  function automatic logic [5:0] slot_to_bin(input logic [5:0] slot);
    if (slot <= 6'd4)       return slot + 6'd38;
    else if (slot <= 6'd17) return slot + 6'd39;
    else if (slot <= 6'd23) return slot + 6'd40;
    else if (slot <= 6'd29) return slot - 6'd23;
    else if (slot <= 6'd42) return slot - 6'd22;
    else                    return slot - 6'd21;
  endfunction

  // Inverse of slot_to_bin; non-data bins return slot 0 and are never used as data.
  function automatic logic [5:0] bin_to_slot(input logic [5:0] bin);
    if (bin >= 6'd1 && bin <= 6'd6)        return bin + 6'd23;
    else if (bin >= 6'd8 && bin <= 6'd20)  return bin + 6'd22;
    else if (bin >= 6'd22 && bin <= 6'd26) return bin + 6'd21;
    else if (bin >= 6'd38 && bin <= 6'd42) return bin - 6'd38;
    else if (bin >= 6'd44 && bin <= 6'd56) return bin - 6'd39;
    else if (bin >= 6'd58)                 return bin - 6'd40;
    else                                   return 6'd0;
  endfunction

  function automatic logic is_null(input logic [5:0] bin);
    return (bin == DC_BIN) || (bin >= NULL_LO && bin <= NULL_HI);
  endfunction

  function automatic logic is_pilot(input logic [5:0] bin);
    return (bin == PILOT_BIN_P7) || (bin == PILOT_BIN_P21) ||
           (bin == PILOT_BIN_M21) || (bin == PILOT_BIN_M7);
  endfunction

endpackage

// File: rtl/pilot_lfsr.sv
// Pilot polarity generator: x^7+x^4+1 LFSR, one output bit per OFDM symbol.
module pilot_lfsr #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Load,
  input  logic Advance,
  output logic Bit
);

  logic [6:0] lfsr_q, lfsr_d;

  assign Bit = lfsr_q[6] ^ lfsr_q[3];

  always_comb begin
    lfsr_d = lfsr_q;
    if (Load)         lfsr_d = SEED;
    else if (Advance) lfsr_d = {lfsr_q[5:0], Bit};
  end

  always_ff @(posedge Clock) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/subcarrier_mapper.sv
// BPSK subcarrier mapper: ping-pong 48-bit symbol buffers feeding 64 IFFT bins with pilots and nulls.
module subcarrier_mapper #(
  parameter int         N_CBPS     = 48,
  parameter logic [6:0] PILOT_SEED = 7'h7F
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       FrameStart,
  input  logic       InBit,
  input  logic       InValid,
  output logic       InReady,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [1:0] OutVal,
  output logic [5:0] OutIndex,
  output logic       OutLast,
  output logic [3:0] dbg_buf_state
);
  import tx_ofdm_pkg::*;

  localparam logic [5:0] LAST_SLOT = 6'(N_CBPS - 1);

  buf_state_e        state_q [2];
  buf_state_e        state_d [2];
  logic [N_CBPS-1:0] buf_q [2];
  logic [N_CBPS-1:0] buf_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [5:0]        out_idx_q, out_idx_d;
  logic              in_acc, out_xfer, last_xfer, pilot_bit, data_bit;
  logic [5:0]        rd_slot;
  logic [1:0]        val;

  // Handshakes: a beat moves when valid && ready at a rising edge; FrameStart voids both beats that cycle.
  assign InReady   = (state_q[wr_sel_q] == BUF_EMPTY) || (state_q[wr_sel_q] == BUF_FILLING);
  assign in_acc    = InValid && InReady && !FrameStart;
  assign out_xfer  = out_valid_q && OutReady && !FrameStart;
  assign last_xfer = out_xfer && (out_idx_q == LAST_BIN);

  pilot_lfsr #(.SEED(PILOT_SEED)) u_pilot_lfsr (
    .Clock  (Clock),
    .Reset  (Reset),
    .Load   (FrameStart),
    .Advance(last_xfer),
    .Bit    (pilot_bit)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wr_sel_d    = wr_sel_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    bit_cnt_d   = bit_cnt_q;
    out_idx_d   = out_idx_q;
    if (FrameStart) begin
      state_d[0]  = BUF_EMPTY;
      state_d[1]  = BUF_EMPTY;
      wr_sel_d    = 1'b0;
      out_sel_d   = 1'b0;
      out_valid_d = 1'b0;
      bit_cnt_d   = 6'd0;
      out_idx_d   = 6'd0;
    end else begin
      if (in_acc) begin
        buf_d[wr_sel_q][bit_cnt_q] = InBit;
        if (bit_cnt_q == LAST_SLOT) begin
          state_d[wr_sel_q] = BUF_FULL;
          bit_cnt_d         = 6'd0;
          wr_sel_d          = !wr_sel_q;
        end else begin
          state_d[wr_sel_q] = BUF_FILLING;
          bit_cnt_d         = bit_cnt_q + 6'd1;
        end
      end
      if (out_xfer) begin
        if (last_xfer) begin
          state_d[out_sel_q] = BUF_EMPTY;
          out_sel_d          = !out_sel_q;
          out_valid_d        = 1'b0;
          out_idx_d          = 6'd0;
        end else begin
          out_idx_d = out_idx_q + 6'd1;
        end
      end
      // Launch looks at next-state so a just-filled buffer or a back-to-back symbol starts without a bubble.
      if (!out_valid_d && state_d[out_sel_d] == BUF_FULL) begin
        state_d[out_sel_d] = BUF_OUTPUT;
        out_valid_d        = 1'b1;
        out_idx_d          = 6'd0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q[0]  <= BUF_EMPTY;
      state_q[1]  <= BUF_EMPTY;
      wr_sel_q    <= 1'b0;
      out_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      bit_cnt_q   <= 6'd0;
      out_idx_q   <= 6'd0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      wr_sel_q    <= wr_sel_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign rd_slot  = bin_to_slot(out_idx_q);
  assign data_bit = buf_q[out_sel_q][rd_slot];

  // Bin +21 carries the inverted pilot; the other three carry p_n directly.
  always_comb begin
    val = VAL_ZERO;
    if (out_valid_q && !is_null(out_idx_q)) begin
      if (out_idx_q == PILOT_BIN_P21) val = pilot_bit ? VAL_POS : VAL_NEG;
      else if (is_pilot(out_idx_q))   val = pilot_bit ? VAL_NEG : VAL_POS;
      else                            val = data_bit ? VAL_POS : VAL_NEG;
    end
  end

  assign OutValid      = out_valid_q;
  assign OutVal        = val;
  assign OutIndex      = out_idx_q;
  assign OutLast       = out_valid_q && (out_idx_q == LAST_BIN);
  assign dbg_buf_state = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_subcarrier_mapper.sv
// Directed bench for subcarrier_mapper: symbol contents, pilots, latency, back-pressure, reset and FrameStart.
module tb_subcarrier_mapper;

  logic       Clock = 1'b0;
  logic       Reset, FrameStart, InBit, InValid, OutReady;
  logic       InReady, OutValid, OutLast;
  logic [1:0] OutVal;
  logic [5:0] OutIndex;
  logic [3:0] dbg_buf_state;

  subcarrier_mapper dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .FrameStart   (FrameStart),
    .InBit        (InBit),
    .InValid      (InValid),
    .InReady      (InReady),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .OutVal       (OutVal),
    .OutIndex     (OutIndex),
    .OutLast      (OutLast),
    .dbg_buf_state(dbg_buf_state)
  );

  always #5 Clock = ~Clock;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_acc_cyc = 0;
  int         stall_viol = 0;
  logic       stalled_prev = 1'b0;
  logic [1:0] prev_val;
  logic [5:0] prev_idx;
  logic [8:0] obs_q[$];
  int         obs_cyc_q[$];
  logic [8:0] exp_q[$];
  int         slot_of_bin[64];
  int         kind_of_bin[64];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (InValid && InReady) last_acc_cyc = cyc;
    if (OutValid && OutReady) begin
      obs_q.push_back({OutIndex, OutVal, OutLast});
      obs_cyc_q.push_back(cyc);
    end
    if (stalled_prev && (!OutValid || OutVal !== prev_val || OutIndex !== prev_idx))
      stall_viol++;
    stalled_prev = OutValid && !OutReady && !Reset && !FrameStart;
    prev_val     = OutVal;
    prev_idx     = OutIndex;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic frame_start(input logic with_bit);
    FrameStart = 1'b1;
    InValid    = with_bit;
    InBit      = 1'b1;
    step();
    FrameStart = 1'b0;
    InValid    = 1'b0;
  endtask

  // Leaves InValid high so consecutive calls stream without gaps.
  task automatic send_bits(input logic [47:0] pat, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      InBit   = pat[i];
      InValid = 1'b1;
      t = 0;
      @(negedge Clock);
      while (!InReady && t < 500) begin
        @(negedge Clock);
        t++;
      end
      if (!InReady) begin
        chk("in_ready_timeout", {31'd0, InReady}, 32'd1);
        break;
      end
      step();
    end
  endtask

  task automatic push_symbol(input logic [47:0] pat, input logic pneg);
    logic [1:0] v;
    for (int b = 0; b < 64; b++) begin
      case (kind_of_bin[b])
        1:       v = pat[slot_of_bin[b]] ? 2'b01 : 2'b11;
        2:       v = ((b == 21) ^ pneg) ? 2'b11 : 2'b01;
        default: v = 2'b00;
      endcase
      exp_q.push_back({6'(b), v, (b == 63)});
    end
  endtask

  task automatic check_symbols(input string tag, input int nsym,
                               output int c0, output int c63, output int c64);
    int t;
    logic [8:0] o, e;
    int oc;
    c0 = -1; c63 = -1; c64 = -1;
    t = 0;
    while (obs_q.size() < nsym * 64 && t < 4000) begin
      @(negedge Clock);
      t++;
    end
    #1;
    chk({tag, "_count"}, obs_q.size(), nsym * 64);
    for (int k = 0; k < nsym * 64 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
      o  = obs_q.pop_front();
      oc = obs_cyc_q.pop_front();
      e  = exp_q.pop_front();
      if (k == 0)  c0  = oc;
      if (k == 63) c63 = oc;
      if (k == 64) c64 = oc;
      chk($sformatf("%s_s%0d_bin%0d", tag, k / 64, k % 64), o, e);
    end
    exp_q.delete();
  endtask

  logic [47:0] pats[5];
  int a48, ready_cyc, c0, c63, c64, t, k;

  initial begin
    Reset = 1'b1; FrameStart = 1'b0; InBit = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    for (int b = 0; b < 64; b++) begin
      kind_of_bin[b] = 0;
      slot_of_bin[b] = 0;
    end
    k = 0;
    for (int sc = -26; sc <= 26; sc++) begin
      if (sc != 0 && sc != 7 && sc != -7 && sc != 21 && sc != -21) begin
        kind_of_bin[(sc < 0) ? sc + 64 : sc] = 1;
        slot_of_bin[(sc < 0) ? sc + 64 : sc] = k;
        k++;
      end
    end
    kind_of_bin[7] = 2; kind_of_bin[21] = 2; kind_of_bin[43] = 2; kind_of_bin[57] = 2;

    repeat (3) step();
    chk("rst_out_valid", OutValid, 0);
    chk("rst_out_val", OutVal, 0);
    chk("rst_out_index", OutIndex, 0);
    chk("rst_out_last", OutLast, 0);
    chk("rst_in_ready", InReady, 1);
    chk("rst_buf_state", dbg_buf_state, 0);
    Reset = 1'b0;
    step();

    // All ones: data +1, pilots p0 = +1, bin 21 inverted.
    OutReady = 1'b1;
    frame_start(1'b0);
    send_bits({48{1'b1}}, 48);
    InValid = 1'b0;
    a48 = last_acc_cyc;
    push_symbol({48{1'b1}}, 1'b0);
    check_symbols("ones", 1, c0, c63, c64);
    chk("ones_latency", c0, a48 + 1);

    // Five zero symbols: p0..p3 = +1, p4 = -1.
    frame_start(1'b0);
    for (int s = 0; s < 5; s++) begin
      send_bits(48'd0, 48);
      push_symbol(48'd0, s == 4);
    end
    InValid = 1'b0;
    check_symbols("zeros", 5, c0, c63, c64);

    // 96 contiguous bits; FrameStart must also reload the advanced LFSR.
    frame_start(1'b0);
    send_bits(48'h0123_4567_89AB, 48);
    a48 = last_acc_cyc;
    send_bits(48'hFEDC_BA98_7654, 48);
    chk("inready_low_after_96", InReady, 0);
    InValid = 1'b0;
    t = 0;
    while (!InReady && t < 300) begin
      step();
      t++;
    end
    ready_cyc = cyc;
    chk("inready_return", InReady, 1);
    push_symbol(48'h0123_4567_89AB, 1'b0);
    push_symbol(48'hFEDC_BA98_7654, 1'b0);
    check_symbols("b2b", 2, c0, c63, c64);
    chk("b2b_first_valid", c0, a48 + 1);
    chk("b2b_ready_after_last", ready_cyc, c63 + 1);
    chk("b2b_no_bubble", c64, c63 + 1);

    // Random OutReady back-pressure over five symbols.
    frame_start(1'b0);
    for (int s = 0; s < 5; s++) begin
      pats[s] = {$urandom, $urandom};
      push_symbol(pats[s], s == 4);
    end
    fork
      begin
        for (int s = 0; s < 5; s++) send_bits(pats[s], 48);
        InValid = 1'b0;
      end
      begin
        for (int i = 0; i < 700; i++) begin
          step();
          OutReady = 1'($urandom_range(0, 1));
        end
      end
    join
    OutReady = 1'b1;
    check_symbols("stall", 5, c0, c63, c64);
    chk("stall_stable", stall_viol, 0);

    // Reset mid-symbol: partial data dropped and pilots back to p0.
    send_bits(48'h5555_5555_5555, 30);
    InValid = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_buf_state", dbg_buf_state, 0);
    chk("midrst_out_valid", OutValid, 0);
    chk("midrst_in_ready", InReady, 1);
    send_bits(48'h9C3A_E17B_0D64, 48);
    InValid = 1'b0;
    chk("midrst_no_early_out", obs_q.size(), 0);
    chk("midrst_valid_after_48", OutValid, 1);
    push_symbol(48'h9C3A_E17B_0D64, 1'b0);
    check_symbols("midrst", 1, c0, c63, c64);

    // FrameStart colliding with a bit at position 20.
    send_bits(48'hFFFF_FFFF_FFFF, 20);
    frame_start(1'b1);
    chk("fs_buf_state", dbg_buf_state, 0);
    chk("fs_out_valid", OutValid, 0);
    chk("fs_in_ready", InReady, 1);
    send_bits(48'h3E81_7C02_F5AA, 48);
    InValid = 1'b0;
    push_symbol(48'h3E81_7C02_F5AA, 1'b0);
    check_symbols("fs_drop", 1, c0, c63, c64);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
